// File: rtl/vga_pattern_gen_param.sv
// Parametrised VGA timing and eight-pattern test generator with a two-stage output pipeline.
// Optional feature macro VGA_PATTERN_ANIM_EN turns pattern 7 into a moving vertical bar.
module vga_pattern_gen_param #(
    parameter int   VIDEO_WIDTH = 3,
    parameter int   ACTIVE_COLS = 640,
    parameter int   ACTIVE_ROWS = 480,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_POL    = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [2:0]             i_pattern,
    input  logic                   i_enable,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic [VIDEO_WIDTH-1:0] o_red,
    output logic [VIDEO_WIDTH-1:0] o_green,
    output logic [VIDEO_WIDTH-1:0] o_blue,
    output logic                   o_frame_start
);

    localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] COL_LAST = 12'(TOTAL_COLS - 1);
    localparam logic [11:0] ROW_LAST = 12'(TOTAL_ROWS - 1);
    localparam logic [11:0] AC       = 12'(ACTIVE_COLS);
    localparam logic [11:0] AR       = 12'(ACTIVE_ROWS);
    localparam logic [11:0] HS_START = 12'(ACTIVE_COLS + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(ACTIVE_COLS + H_FRONT + H_SYNC);
    localparam logic [11:0] VS_START = 12'(ACTIVE_ROWS + V_FRONT);
    localparam logic [11:0] VS_END   = 12'(ACTIVE_ROWS + V_FRONT + V_SYNC);
    localparam logic [11:0] BAR_LAST = 12'(ACTIVE_COLS / 8 - 1);

    localparam logic [VIDEO_WIDTH-1:0] FULL = {VIDEO_WIDTH{1'b1}};

    logic [11:0] col_q, row_q;
    logic [11:0] bar_sub_q;
    logic [2:0]  bar_idx_q;
    logic [2:0]  pat_q;
    logic        col_wrap, row_wrap, frame_end;

    assign col_wrap  = (col_q == COL_LAST);
    assign row_wrap  = (row_q == ROW_LAST);
    assign frame_end = col_wrap && row_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_wrap ? 12'd0 : col_q + 12'd1;
            if (col_wrap) begin
                row_q <= row_wrap ? 12'd0 : row_q + 12'd1;
            end
        end
    end

    // Bar index tracks col / (ACTIVE_COLS/8) without a divider.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bar_sub_q <= '0;
            bar_idx_q <= '0;
        end else if (col_wrap) begin
            bar_sub_q <= '0;
            bar_idx_q <= '0;
        end else if (bar_sub_q == BAR_LAST) begin
            bar_sub_q <= '0;
            bar_idx_q <= bar_idx_q + 3'd1;
        end else begin
            bar_sub_q <= bar_sub_q + 12'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pat_q <= '0;
        end else if (frame_end) begin
            pat_q <= i_pattern;
        end
    end

    logic pat7_on;

`ifdef VGA_PATTERN_ANIM_EN
    logic [11:0] offset_q;
    logic [11:0] dist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            offset_q <= '0;
        end else if (frame_end) begin
            offset_q <= (offset_q == AC - 12'd1) ? 12'd0 : offset_q + 12'd1;
        end
    end

    // Distance from the bar's left edge, wrapping around the active width.
    assign dist    = (col_q >= offset_q) ? (col_q - offset_q) : (col_q + AC - offset_q);
    assign pat7_on = (dist < 12'd8);
`else
    assign pat7_on = (col_q == 12'd0) || (col_q == AC - 12'd1) ||
                     (row_q == 12'd0) || (row_q == AR - 12'd1);
`endif

    logic [2:0]             bar_code;
    logic [VIDEO_WIDTH-1:0] ramp;
    logic [VIDEO_WIDTH-1:0] red_c, green_c, blue_c;
    logic                   active;

    assign active = (col_q < AC) && (row_q < AR);
    assign ramp   = VIDEO_WIDTH'(col_q >> 6);

    always_comb begin
        bar_code = 3'b000;
        case (bar_idx_q)
            3'd0:    bar_code = 3'b111;
            3'd1:    bar_code = 3'b110;
            3'd2:    bar_code = 3'b011;
            3'd3:    bar_code = 3'b010;
            3'd4:    bar_code = 3'b101;
            3'd5:    bar_code = 3'b100;
            3'd6:    bar_code = 3'b001;
            default: bar_code = 3'b000;
        endcase
    end

    always_comb begin
        red_c   = '0;
        green_c = '0;
        blue_c  = '0;
        case (pat_q)
            3'd1: red_c   = FULL;
            3'd2: green_c = FULL;
            3'd3: blue_c  = FULL;
            3'd4: begin
                if (col_q[4] ^ row_q[4]) begin
                    red_c   = FULL;
                    green_c = FULL;
                    blue_c  = FULL;
                end
            end
            3'd5: begin
                red_c   = {VIDEO_WIDTH{bar_code[2]}};
                green_c = {VIDEO_WIDTH{bar_code[1]}};
                blue_c  = {VIDEO_WIDTH{bar_code[0]}};
            end
            3'd6: begin
                red_c   = ramp;
                green_c = ramp;
                blue_c  = ramp;
            end
            3'd7: begin
                if (pat7_on) begin
                    red_c   = FULL;
                    green_c = FULL;
                    blue_c  = FULL;
                end
            end
            default: ;
        endcase
    end

    logic                   hs_s1, vs_s1, de_s1, fs_s1;
    logic [VIDEO_WIDTH-1:0] red_s1, green_s1, blue_s1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_s1    <= 1'b0;
            vs_s1    <= 1'b0;
            de_s1    <= 1'b0;
            fs_s1    <= 1'b0;
            red_s1   <= '0;
            green_s1 <= '0;
            blue_s1  <= '0;
        end else begin
            hs_s1    <= (col_q >= HS_START) && (col_q < HS_END);
            vs_s1    <= (row_q >= VS_START) && (row_q < VS_END);
            de_s1    <= active;
            fs_s1    <= (col_q == 12'd0) && (row_q == 12'd0);
            red_s1   <= (active && i_enable) ? red_c   : '0;
            green_s1 <= (active && i_enable) ? green_c : '0;
            blue_s1  <= (active && i_enable) ? blue_c  : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
        end else begin
            o_hsync       <= hs_s1 ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= vs_s1 ? SYNC_POL : ~SYNC_POL;
            o_de          <= de_s1;
            o_frame_start <= fs_s1;
            o_red         <= red_s1;
            o_green       <= green_s1;
            o_blue        <= blue_s1;
        end
    end

endmodule

// File: doc/vga_pattern_gen_param.md
# vga_pattern_gen_param

Parametrised VGA timing and test-pattern engine. It produces sync, data-enable and N-bit RGB video from a single pixel clock, with programmable active area, porches and sync polarity. It offers eight selectable patterns, and pattern changes take effect only on frame boundaries. It replaces the fixed 640x480 / 3-bit sync-pulse, pattern and porch chain, and sits directly after the pixel-clock PLL, driving the VGA pins.

## Interface
Parameters:
- VIDEO_WIDTH, 3: bits per colour channel (1..8).
- ACTIVE_COLS, 640: visible pixels per line; must be a multiple of 8.
- ACTIVE_ROWS, 480: visible lines per frame.
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48: horizontal porch and pulse widths, in pixels.
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33: vertical porch and pulse widths, in lines.
- SYNC_POL, 0: asserted sync level (0 = active-low).

Derived values:
- TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK.
- TOTAL_ROWS is defined the same way from the vertical parameters.
- Counters are 12 bits wide.

Ports:
- i_clk, in, 1: pixel clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_pattern, in, 3: requested pattern; sampled only at frame start.
- i_enable, in, 1: 0 forces the colour outputs to 0; sync and DE keep running.
- o_hsync, out, 1: horizontal sync.
- o_vsync, out, 1: vertical sync.
- o_de, out, 1: data enable; 1 during the active area.
- o_red / o_green / o_blue, out, VIDEO_WIDTH: colour channels.
- o_frame_start, out, 1: one-cycle pulse aligned with the first active pixel (col 0, row 0) on the outputs.

## Operation
- Counters:
  - col counts 0..TOTAL_COLS-1 and wraps to 0.
  - row increments when col wraps, and counts 0..TOTAL_ROWS-1.
  - The active area is col < ACTIVE_COLS and row < ACTIVE_ROWS.
- Sync windows:
  - hsync is asserted (level SYNC_POL) for ACTIVE_COLS+H_FRONT ≤ col < ACTIVE_COLS+H_FRONT+H_SYNC.
  - vsync is defined the same way on row.
- Pattern latch: the active pattern register loads i_pattern on the cycle where col = TOTAL_COLS-1 and row = TOTAL_ROWS-1. A mid-frame change of i_pattern is never visible until the next frame.
- Patterns: "full" means all ones; colours are written {R,G,B}.
  - 0: black.
  - 1: solid red.
  - 2: solid green.
  - 3: solid blue.
  - 4: 16x16 checkerboard; white when col[4]^row[4], else black.
  - 5: eight vertical colour bars, each ACTIVE_COLS/8 pixels wide, in the order white, yellow, cyan, green, magenta, red, blue, black. The bar index comes from a sub-counter and bar counter; no divider is used.
  - 6: grey ramp; every channel = col[VIDEO_WIDTH+5:6], truncated.
  - 7: border; see Configuration.
- Outside the active area, or when i_enable = 0, all colour outputs are 0.

## Timing
- Reset values:
  - col = 0, row = 0, active pattern = 0.
  - o_hsync = o_vsync = ~SYNC_POL (deasserted).
  - o_de = 0, all colour outputs = 0, o_frame_start = 0.
- Reset is asynchronous. Deasserting it mid-frame restarts at col 0 / row 0 on the first clock after release.
- Pipeline: two register stages from counters to pins.
  - Stage 1 registers the counter decodes and pattern selection.
  - Stage 2 registers the outputs.
  - Sync, DE, colour and o_frame_start all take exactly 2 cycles of latency, so they are mutually aligned.
- i_enable is registered in stage 1 and takes effect 2 cycles after a change.
- Simultaneous col wrap and row wrap: row goes to 0 in the same cycle col goes to 0.
- Frame period is TOTAL_COLS × TOTAL_ROWS cycles; with the defaults this is 800 × 525 = 420000.

## Configuration
- VGA_PATTERN_ANIM_EN defined: pattern 7 is a vertical white bar 8 pixels wide on black. Its left edge starts at col 0 after reset, moves +1 pixel per frame, and wraps at ACTIVE_COLS. It uses a 12-bit offset register, which is reset to 0 and updated at the pattern latch point.
- VGA_PATTERN_ANIM_EN undefined: pattern 7 is a static 1-pixel white border on col 0, col ACTIVE_COLS-1, row 0 and row ACTIVE_ROWS-1, black inside. No offset register exists.

## Test plan
- Defaults, release reset: first o_frame_start 2 cycles after release. o_hsync low for exactly 96 cycles starting 658 cycles after release, repeating every 800. o_vsync low for 1600 cycles (rows 490–491). Next o_frame_start at +420000.
- i_pattern = 5 from reset: pixels 0, 80, 160, 240, 320, 400, 480, 560 of row 0 read RGB = 7/7/7, 7/7/0, 0/7/7, 0/7/0, 7/0/7, 7/0/0, 0/0/7, 0/0/0. o_de is 1 for exactly 640 cycles per active line.
- Switch i_pattern from 1 to 2 at row 100: the rest of that frame stays red (7/0/0); the next frame is green (0/7/0) from its first pixel.
- i_enable = 0 for one full frame: all colours are 0 throughout, while sync and DE timing is identical to the reference capture.
- Non-default parameters (ACTIVE_COLS = 320, ACTIVE_ROWS = 240, all porches = 4/8/4, SYNC_POL = 1, VIDEO_WIDTH = 5): frame period = 336 × 256 cycles, sync is active-high, pattern 4 shows full value 31.
- Pattern 7 over 3 frames:
  - With VGA_PATTERN_ANIM_EN: the bar's left edge is at col 0, then 1, then 2.
  - Without it: row 0 is all white, and row 1 is white only at col 0 and col 639.
